cbx_param_shadow: RTL and testbench

- Parametrised X-channel connection block: the successor to the fixed-size cbx_* blocks.
- Channel width, IPIN count and mux size are parameters.
- Feedthrough wires pass the channel through combinationally; one configurable mux per IPIN taps tracks from both channel sides.
- New behaviour: double-buffered configuration. A bit-counted shift chain loads shadow bits, and a validated commit handshake copies them into the active register. IPIN outputs stay gated to 0 until the first good commit.

---
 rtl/cb_cfg_pkg.sv | 32 +++
 rtl/cb_ipin_mux.sv | 26 ++
 rtl/cbx_param_shadow.sv | 137 +++++++++++++
 tb/tb_cbx_param_shadow.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cb_cfg_pkg.sv
// rtl/cb_cfg_pkg.sv - shared constants and helper functions for the X-channel connection block
//
// Purpose : default geometry plus the elaboration-time helpers that size the
//           configuration chain and map IPIN mux inputs onto channel tracks.
// Contents: DEF_* localparams, clog2(), track_idx().
package cb_cfg_pkg;

    localparam int DEF_CHAN_W   = 9;
    localparam int DEF_NUM_IPIN = 4;
    localparam int DEF_MUX_SIZE = 6;
    localparam int DEF_STRIDE   = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Mux input k of pin p taps track (p + (k>>1)*stride) mod chan_w;
    // even/odd k choose the left/right channel side.
    function automatic int track_idx(input int p, input int k, input int stride, input int chan_w);
        return (p + (k >> 1) * stride) % chan_w;
    endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// rtl/cb_ipin_mux.sv - combinational IPIN select mux, unused codes drive 0
//
// Purpose : picks one of MUX_SIZE candidate tracks for a single grid pin.
// Ports   : data_i [MUX_SIZE-1:0]  candidate track values
//           sel_i  [SEL_W-1:0]     select code from the active config
//           out_o                  selected value, 0 when sel_i >= MUX_SIZE
module cb_ipin_mux #(
    parameter int MUX_SIZE = 6,
    parameter int SEL_W    = 3
) (
    input  logic [MUX_SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic                out_o
);

    // Compare against each legal code so out-of-range codes simply match nothing.
    always_comb begin
        out_o = 1'b0;
        for (int k = 0; k < MUX_SIZE; k++) begin
            if (sel_i == SEL_W'(k)) begin
                out_o = data_i[k];
            end
        end
    end

endmodule

// File: rtl/cbx_param_shadow.sv
// rtl/cbx_param_shadow.sv - parametrised X-channel connection block with double-buffered config
//
// Purpose : channel feedthrough plus NUM_IPIN configurable pin muxes. Config is
//           shifted into a shadow chain and copied to the active register only
//           by a commit that arrives after exactly CFG_BITS shifts.
// Ports   : prog_clk, prog_reset (sync, active-high)
//           chanx_left_in/right_in    channel tracks entering each side
//           chanx_left_out/right_out  combinational feedthrough
//           ipin_out                  grid pin drivers, gated until first good commit
//           ccff_head, ccff_en        serial config data / shift enable
//           ccff_tail                 chain output (shadow MSB)
//           ccff_commit               commit request
//           commit_done, cfg_valid, cfg_err  commit status
module cbx_param_shadow
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W   = DEF_CHAN_W,
    parameter int NUM_IPIN = DEF_NUM_IPIN,
    parameter int MUX_SIZE = DEF_MUX_SIZE,
    parameter int STRIDE   = DEF_STRIDE
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    input  logic                ccff_head,
    input  logic                ccff_en,
    output logic                ccff_tail,
    input  logic                ccff_commit,
    output logic                commit_done,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int SEL_W    = clog2(MUX_SIZE);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;
    localparam int CNT_W    = clog2(CFG_BITS + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    // One past full marks an over-shifted chain; the counter parks there.
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                cfg_err_q, cfg_err_d;
    logic                commit_done_q, commit_done_d;

    // Feedthrough
    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    // Chain, counter and commit
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        bit_cnt_d     = bit_cnt_q;
        cfg_valid_d   = cfg_valid_q;
        cfg_err_d     = cfg_err_q;
        commit_done_d = 1'b0;

        if (ccff_commit) begin
            // Commit takes priority; a shift requested alongside it is dropped
            // and flagged, and the commit is judged on the pre-cycle count.
            bit_cnt_d = '0;
            if (bit_cnt_q == CNT_FULL) begin
                active_d      = shadow_q;
                cfg_valid_d   = 1'b1;
                commit_done_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
            if (ccff_en) begin
                cfg_err_d = 1'b1;
            end
        end else if (ccff_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shadow_q      <= '0;
            active_q      <= '0;
            bit_cnt_q     <= '0;
            cfg_valid_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            bit_cnt_q     <= bit_cnt_d;
            cfg_valid_q   <= cfg_valid_d;
            cfg_err_q     <= cfg_err_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign ccff_tail   = shadow_q[CFG_BITS-1];
    assign commit_done = commit_done_q;
    assign cfg_valid   = cfg_valid_q;
    assign cfg_err     = cfg_err_q;

    // IPIN muxes
    logic [NUM_IPIN-1:0][MUX_SIZE-1:0] mux_in;
    logic [NUM_IPIN-1:0]               mux_out;

    for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
        for (genvar k = 0; k < MUX_SIZE; k++) begin : g_in
            if ((k % 2) == 0) begin : g_left
                assign mux_in[p][k] = chanx_left_in[track_idx(p, k, STRIDE, CHAN_W)];
            end else begin : g_right
                assign mux_in[p][k] = chanx_right_in[track_idx(p, k, STRIDE, CHAN_W)];
            end
        end

        cb_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .data_i (mux_in[p]),
            .sel_i  (active_q[p*SEL_W +: SEL_W]),
            .out_o  (mux_out[p])
        );
    end

    // Pins stay quiet until a config has actually been committed.
    assign ipin_out = mux_out & {NUM_IPIN{cfg_valid_q}};

endmodule

// File: tb/tb_cbx_param_shadow.sv
// tb/tb_cbx_param_shadow.sv - directed table-driven bench for cbx_param_shadow
module tb_cbx_param_shadow;

    logic       prog_clk = 1'b0;
    logic       prog_reset;
    logic [8:0] chanx_left_in, chanx_right_in;
    logic [8:0] chanx_left_out, chanx_right_out;
    logic [3:0] ipin_out;
    logic       ccff_head, ccff_en, ccff_tail, ccff_commit;
    logic       commit_done, cfg_valid, cfg_err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 prog_clk = ~prog_clk;

    cbx_param_shadow dut (
        .prog_clk        (prog_clk),
        .prog_reset      (prog_reset),
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out),
        .ipin_out        (ipin_out),
        .ccff_head       (ccff_head),
        .ccff_en         (ccff_en),
        .ccff_tail       (ccff_tail),
        .ccff_commit     (ccff_commit),
        .commit_done     (commit_done),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
    );

    typedef struct {
        logic [11:0] cfg;
        logic [8:0]  left;
        logic [8:0]  right;
        logic [3:0]  exp_ipin;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ccff_en   = 1'b1;
            ccff_head = val[i];
            step();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic commit_pulse();
        ccff_commit = 1'b1;
        step();
        ccff_commit = 1'b0;
    endtask

    task automatic do_reset();
        prog_reset = 1'b1;
        step();
        step();
        prog_reset = 1'b0;
    endtask

    logic [11:0] tail_word;

    initial begin
        // cfg = {sel3, sel2, sel1, sel0}
        vecs[0] = '{12'h004, 9'h100, 9'h000, 4'b0001}; // sel0=4 -> left[8]
        vecs[1] = '{12'h004, 9'h0FE, 9'h000, 4'b1110}; // other pins on left[p]
        vecs[2] = '{12'h020, 9'h001, 9'h000, 4'b0011}; // sel1=4 wraps to left[0]
        vecs[3] = '{12'h028, 9'h000, 9'h001, 4'b0010}; // sel1=5 -> right[0]
        vecs[4] = '{12'hFBE, 9'h1FF, 9'h1FF, 4'b0000}; // codes 6/7 -> 0
        vecs[5] = '{12'h249, 9'h000, 9'h00A, 4'b1010}; // sel=1 -> right[p]
        vecs[6] = '{12'h492, 9'h0A0, 9'h000, 4'b1010}; // sel=2 -> left[p+4]
        vecs[7] = '{12'hA00, 9'h000, 9'h004, 4'b1000}; // sel3=5 -> right[2]

        prog_reset     = 1'b1;
        chanx_left_in  = 9'h1FF;
        chanx_right_in = 9'h1FF;
        ccff_head      = 1'b0;
        ccff_en        = 1'b0;
        ccff_commit    = 1'b0;

        // Reset and passthrough
        do_reset();
        chk("rst_ipin", 32'(ipin_out), 32'h0);
        chk("rst_tail", 32'(ccff_tail), 32'h0);
        chk("rst_valid", 32'(cfg_valid), 32'h0);
        chk("rst_err", 32'(cfg_err), 32'h0);
        chk("rst_done", 32'(commit_done), 32'h0);
        chanx_left_in = 9'h0A5;
        #1;
        chk("pass_right_out", 32'(chanx_right_out), 32'h0A5);
        chk("pass_left_out", 32'(chanx_left_out), 32'h1FF);

        // Table: shift, commit, then check routing
        for (int v = 0; v < 8; v++) begin
            shift_bits(16'(vecs[v].cfg), 12);
            commit_pulse();
            chk($sformatf("v%0d_done", v), 32'(commit_done), 32'h1);
            chk($sformatf("v%0d_valid", v), 32'(cfg_valid), 32'h1);
            chanx_left_in  = vecs[v].left;
            chanx_right_in = vecs[v].right;
            step();
            chk($sformatf("v%0d_done_off", v), 32'(commit_done), 32'h0);
            chk($sformatf("v%0d_ipin", v), 32'(ipin_out), 32'(vecs[v].exp_ipin));
        end

        // Zero-latency routing: toggle the tapped track without a clock edge
        shift_bits(16'h004, 12);
        commit_pulse();
        chanx_left_in  = 9'h100;
        chanx_right_in = 9'h000;
        #1;
        chk("follow_hi", 32'(ipin_out), 32'h1);
        chanx_left_in = 9'h000;
        #1;
        chk("follow_lo", 32'(ipin_out), 32'h0);

        // Miscounted commits leave active alone (pin 3 on left[3] with sel0=4)
        chanx_left_in = 9'h108;
        #1;
        chk("pre_miscount", 32'(ipin_out), 32'b1001);
        shift_bits(16'hFFFF, 11);
        commit_pulse();
        chk("under_done", 32'(commit_done), 32'h0);
        chk("under_err", 32'(cfg_err), 32'h1);
        chk("under_ipin", 32'(ipin_out), 32'b1001);
        shift_bits(16'hFFFF, 13);
        commit_pulse();
        chk("over_done", 32'(commit_done), 32'h0);
        chk("over_ipin", 32'(ipin_out), 32'b1001);
        shift_bits(16'h020, 12);
        commit_pulse();
        chk("recover_done", 32'(commit_done), 32'h1);
        chk("recover_err", 32'(cfg_err), 32'h1);
        chanx_left_in = 9'h001;
        #1;
        chk("recover_ipin", 32'(ipin_out), 32'b0011);

        // Commit held two cycles: second sees count 0
        do_reset();
        shift_bits(16'h004, 12);
        ccff_commit = 1'b1;
        step();
        step();
        ccff_commit = 1'b0;
        chk("hold_done", 32'(commit_done), 32'h0);
        chk("hold_err", 32'(cfg_err), 32'h1);
        chk("hold_valid", 32'(cfg_valid), 32'h1);

        // Shift and commit together: commit uses pre-cycle shadow, shift dropped
        do_reset();
        shift_bits(16'h420, 12);
        ccff_en     = 1'b1;
        ccff_head   = 1'b1;
        ccff_commit = 1'b1;
        step();
        ccff_en     = 1'b0;
        ccff_head   = 1'b0;
        ccff_commit = 1'b0;
        chk("both_done", 32'(commit_done), 32'h1);
        chk("both_err", 32'(cfg_err), 32'h1);
        chk("both_tail", 32'(ccff_tail), 32'h0);
        chanx_left_in  = 9'h081;
        chanx_right_in = 9'h000;
        #1;
        chk("both_ipin", 32'(ipin_out), 32'b1011);

        // Chain readout: pattern re-emerges MSB first after 12 shifts
        do_reset();
        shift_bits(16'hB3C, 12);
        tail_word = '0;
        for (int i = 11; i >= 0; i--) begin
            tail_word[i] = ccff_tail;
            ccff_en   = 1'b1;
            ccff_head = 1'b0;
            step();
        end
        ccff_en = 1'b0;
        chk("tail_word", 32'(tail_word), 32'hB3C);
        chk("tail_flushed", 32'(ccff_tail), 32'h0);

        // Reset mid-shift clears chain and count
        shift_bits(16'hFFFF, 5);
        prog_reset = 1'b1;
        step();
        prog_reset = 1'b0;
        chk("midrst_tail", 32'(ccff_tail), 32'h0);
        chk("midrst_valid", 32'(cfg_valid), 32'h0);
        shift_bits(16'h004, 12);
        commit_pulse();
        chk("midrst_done", 32'(commit_done), 32'h1);
        chk("midrst_err", 32'(cfg_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
